// File: rtl/frame_sequencer_if.sv
// Pixel-stream bundle feeding the frame sequencer: one pixel per valid cycle,
// with start-of-frame and end-of-line markers qualified by pix_valid.
`ifndef LOC_SIZE
`define LOC_SIZE 12
`endif

interface frame_sequencer_if;
  logic pix_valid;
  logic pix_sof;
  logic pix_eol;

  modport master (output pix_valid, output pix_sof, output pix_eol);
  modport slave  (input  pix_valid, input  pix_sof, input  pix_eol);
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: gates a pixel stream into downstream x/y/frame location
// counter advances, generating hsync/vsync strobes and flagging geometry errors.
`ifndef LOC_SIZE
`define LOC_SIZE 12
`endif

// state    | meaning
// IDLE     | not armed; cfg latched when arm is seen
// WAIT_SOF | armed, dropping pixels until the first start-of-frame
// ACTIVE   | forwarding pixels, tracking col/row/frame position
// FINISH   | single cycle, pulses done, returns to IDLE
module frame_sequencer #(
  parameter int FRAMES_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  frame_sequencer_if.slave        pix,
  input  logic [`LOC_SIZE-1:0]    cfg_width,
  input  logic [`LOC_SIZE-1:0]    cfg_height,
  input  logic [FRAMES_W-1:0]     cfg_frames,
  input  logic                    arm,
  input  logic                    abort,
  output logic                    en,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    busy,
  output logic                    done,
  output logic                    err_geom
);

  localparam int LW = `LOC_SIZE;
  localparam logic [LW-1:0]       ONE_L = 1;
  localparam logic [FRAMES_W-1:0] ONE_F = 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, FINISH} state_t;

  state_t              state, state_nx;
  logic [LW-1:0]       width_q, height_q;
  logic [FRAMES_W-1:0] frames_q;
  logic [LW-1:0]       col, row, col_nx, row_nx, col_eff, row_eff;
  logic [FRAMES_W-1:0] fcnt, fcnt_nx;
  logic                err_nx, at_origin, last_col, line_end, frame_end;
  logic                arm_take;

  assign arm_take  = (state == IDLE) && arm;
  assign at_origin = (col == '0) && (row == '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    en        = 1'b0;
    hsync     = 1'b0;
    vsync     = 1'b0;
    done      = 1'b0;
    col_nx    = col;
    row_nx    = row;
    fcnt_nx   = fcnt;
    err_nx    = err_geom;
    col_eff   = col;
    row_eff   = row;
    last_col  = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;

    case (state)
      IDLE: begin
        if (arm) state_nx = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (abort) state_nx = FINISH;
        else if (pix.pix_valid && pix.pix_sof) begin
          en       = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort) state_nx = FINISH;
        else if (pix.pix_valid) en = 1'b1;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (en) begin
      // A frame starts either on an explicit sof or on the pixel right after a frame end.
      vsync = pix.pix_sof || at_origin;
      if (vsync) begin
        col_eff = '0;
        row_eff = '0;
      end
      hsync     = !vsync && (col_eff == '0);
      last_col  = (col_eff == width_q - ONE_L);
      line_end  = pix.pix_eol || last_col;
      frame_end = line_end && (row_eff == height_q - ONE_L);
      if (pix.pix_eol != last_col) err_nx = 1'b1;
      if (pix.pix_sof && (state == ACTIVE) && !at_origin) err_nx = 1'b1;
      col_nx = line_end ? '0 : col_eff + ONE_L;
      row_nx = frame_end ? '0 : (line_end ? row_eff + ONE_L : row_eff);
      if (frame_end) begin
        fcnt_nx = fcnt + ONE_F;
        if ((frames_q != '0) && (fcnt_nx == frames_q)) state_nx = FINISH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_q  <= '0;
      height_q <= '0;
      frames_q <= '0;
      col      <= '0;
      row      <= '0;
      fcnt     <= '0;
      err_geom <= 1'b0;
    end else if (arm_take) begin
      width_q  <= cfg_width;
      height_q <= cfg_height;
      frames_q <= cfg_frames;
      col      <= '0;
      row      <= '0;
      fcnt     <= '0;
      err_geom <= 1'b0;
    end else begin
      col      <= col_nx;
      row      <= row_nx;
      fcnt     <= fcnt_nx;
      err_geom <= err_nx;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: per-cycle expected outputs are queued
// by the stimulus side and compared by an independent monitor on the falling edge.
`ifndef LOC_SIZE
`define LOC_SIZE 12
`endif

module tb_frame_sequencer;
  localparam int LW = `LOC_SIZE;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [LW-1:0] cfg_width, cfg_height;
  logic [FW-1:0] cfg_frames;
  logic          arm, abort;
  logic          en, hsync, vsync, busy, done, err_geom;

  frame_sequencer_if pif ();

  frame_sequencer #(.FRAMES_W(FW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix        (pif.slave),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_frames (cfg_frames),
    .arm        (arm),
    .abort      (abort),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .busy       (busy),
    .done       (done),
    .err_geom   (err_geom)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [5:0]  exp_q[$];
  string       name_q[$];
  logic        exp_err = 1'b0;
  logic [5:0]  mon_exp;
  string       mon_name;

  // Vector order: en, hsync, vsync, busy, done, err_geom
  function automatic logic [5:0] ex(input logic e_en, input logic hs, input logic vs,
                                    input logic b, input logic d);
    return {e_en, hs, vs, b, d, exp_err};
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: en/hs/vs/busy/done/err got %b required %b at %0t", nm, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        chk(mon_name, {en, hsync, vsync, busy, done, err_geom}, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic v, input logic s, input logic e, input logic a,
                     input logic ab, input logic [5:0] exv, input string nm);
    @(posedge clk); #1;
    pif.pix_valid = v;
    pif.pix_sof   = s;
    pif.pix_eol   = e;
    arm           = a;
    abort         = ab;
    cfg_width     = LW'($urandom);
    cfg_height    = LW'($urandom);
    cfg_frames    = FW'($urandom);
    exp_q.push_back(exv);
    name_q.push_back(nm);
  endtask

  task automatic do_arm(input int w, input int h, input int f);
    @(posedge clk); #1;
    pif.pix_valid = 1'($urandom);
    pif.pix_sof   = 1'($urandom);
    pif.pix_eol   = 1'($urandom);
    arm           = 1'b1;
    abort         = 1'b0;
    cfg_width     = LW'(w);
    cfg_height    = LW'(h);
    cfg_frames    = FW'(f);
    exp_q.push_back(ex(0, 0, 0, 0, 0));
    name_q.push_back("arm_idle");
    exp_err = 1'b0;
  endtask

  function automatic logic noise();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic frame_pixels(input int w, input int h, input int gap_max);
    for (int k = 0; k < w * h; k++) begin
      repeat ($urandom_range(0, gap_max))
        cyc(0, 1'($urandom), 1'($urandom), noise(), 0, ex(0, 0, 0, 1, 0), "gap");
      cyc(1, k == 0, (k % w) == (w - 1), noise(), 0,
          ex(1, (k != 0) && ((k % w) == 0), k == 0, 1, 0), "pixel");
    end
  endtask

  task automatic run_capture(input int w, input int h, input int f, input int n_pre,
                             input int gap_max);
    do_arm(w, h, f);
    for (int i = 0; i < n_pre; i++)
      cyc(1, 0, 1'($urandom), noise(), 0, ex(0, 0, 0, 1, 0), "pre_sof_drop");
    for (int fr = 0; fr < f; fr++) frame_pixels(w, h, gap_max);
    cyc(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, ex(0, 0, 0, 1, 1), "finish_done");
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0), "idle_after");
  endtask

  task automatic run_continuous(input int w, input int h, input int nfr, input int gap_max);
    int part;
    do_arm(w, h, 0);
    for (int fr = 0; fr < nfr; fr++) frame_pixels(w, h, gap_max);
    part = $urandom_range(0, w * h - 1);
    for (int k = 0; k < part; k++)
      cyc(1, k == 0, (k % w) == (w - 1), noise(), 0,
          ex(1, (k != 0) && ((k % w) == 0), k == 0, 1, 0), "cont_partial");
    cyc(1, 1'($urandom), 1'($urandom), 0, 1, ex(0, 0, 0, 1, 0), "abort_pixel");
    cyc(1, 0, 0, 0, 0, ex(0, 0, 0, 1, 1), "abort_done");
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0), "idle_after_abort");
  endtask

  initial begin
    pif.pix_valid = 1'b1;
    pif.pix_sof   = 1'b1;
    pif.pix_eol   = 1'b0;
    arm           = 1'b1;
    abort         = 1'b0;
    cfg_width     = 4;
    cfg_height    = 2;
    cfg_frames    = 1;
    #13;
    chk("reset_outputs", {en, hsync, vsync, busy, done, err_geom}, 6'b0);
    #20;
    chk("reset_outputs_held", {en, hsync, vsync, busy, done, err_geom}, 6'b0);
    arm = 1'b0;
    reset_n = 1'b1;

    // Basic 4x2 single frame, then drops before sof
    run_capture(4, 2, 1, 0, 0);
    run_capture(4, 2, 1, 3, 1);

    // Early eol on the third pixel
    do_arm(4, 2, 1);
    cyc(1, 1, 0, 0, 0, ex(1, 0, 1, 1, 0), "eol_p0");
    cyc(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0), "eol_p1");
    cyc(1, 0, 1, 0, 0, ex(1, 0, 0, 1, 0), "eol_early");
    exp_err = 1'b1;
    cyc(1, 0, 0, 0, 0, ex(1, 1, 0, 1, 0), "eol_next_hsync");
    cyc(1, 0, 0, 1, 0, ex(1, 0, 0, 1, 0), "eol_p4");
    cyc(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0), "eol_p5");
    cyc(1, 0, 1, 0, 0, ex(1, 0, 0, 1, 0), "eol_p6");
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 1, 1), "eol_done");
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0), "err_sticky_idle");
    run_capture(3, 2, 1, 0, 1);

    // Mid-frame sof restarts the frame and flags an error
    do_arm(4, 2, 1);
    cyc(1, 1, 0, 0, 0, ex(1, 0, 1, 1, 0), "msof_p0");
    cyc(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0), "msof_p1");
    cyc(1, 1, 0, 0, 0, ex(1, 0, 1, 1, 0), "msof_restart");
    exp_err = 1'b1;
    for (int k = 1; k < 8; k++)
      cyc(1, 0, (k % 4) == 3, 0, 0, ex(1, k == 4, 0, 1, 0), "msof_rest");
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 1, 1), "msof_done");
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0), "msof_idle");

    // Width 1: sof and eol on the same pixel
    run_capture(1, 2, 1, 0, 0);

    // Continuous over 3 frames, abort with a valid pixel
    run_continuous(4, 2, 3, 1);

    // Abort while waiting for sof
    do_arm(3, 3, 2);
    cyc(1, 0, 0, 0, 1, ex(0, 0, 0, 1, 0), "abort_wait");
    cyc(1, 1, 0, 0, 0, ex(0, 0, 0, 1, 1), "abort_wait_done");
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0), "abort_wait_idle");

    // Asynchronous reset mid-line, then clean restart
    do_arm(4, 2, 1);
    cyc(1, 1, 0, 0, 0, ex(1, 0, 1, 1, 0), "rst_p0");
    cyc(1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0), "rst_p1");
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_immediate", {en, hsync, vsync, busy, done, err_geom}, 6'b0);
    @(posedge clk); #3;
    chk("async_reset_no_done", {en, hsync, vsync, busy, done, err_geom}, 6'b0);
    reset_n = 1'b1;
    exp_err = 1'b0;
    pif.pix_valid = 1'b0;
    run_capture(4, 2, 1, 0, 0);

    // Randomised geometry and frame counts
    for (int it = 0; it < 20; it++)
      run_capture($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 3),
                  $urandom_range(0, 3), 2);
    for (int it = 0; it < 5; it++)
      run_continuous($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 3), 1);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
